// File: rtl/mul_div_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The stage drives the operands and controls; the unit returns status and the HI/LO registers.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU on magnitudes with a final sign-fix cycle, plus MTHI/MTLO.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst,
  mul_div_if.slave bus
);
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ZERO
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             div_op;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic             accept;
  logic             is_md;
  logic             is_div;
  logic             is_sgn;
  logic             b_zero;
  logic             last_step;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [AW-1:0]      step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand decode and next-state logic.
  always_comb begin
    accept    = (state == S_IDLE) && bus.start && !bus.flush;
    is_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_sgn    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    b_zero    = (bus.b == '0);
    a_neg     = is_sgn && bus.a[WIDTH-1];
    b_neg     = is_sgn && bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    last_step = (cnt == CNT_W'(1));

    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept && is_md)
          state_n = (is_div && b_zero) ? S_ZERO : S_RUN;
      end
      S_RUN: begin
        if (bus.flush)
          state_n = S_IDLE;
        else if (last_step)
          state_n = S_FIX;
      end
      S_FIX:  state_n = S_IDLE;
      S_ZERO: state_n = S_IDLE;
    endcase
  end

  // One iteration step. Multiply: acc = {partial (W+1), multiplier (W)}, add then
  // shift right. Divide: acc = {remainder (W+1), dividend/quotient (W)}, the
  // trial subtraction runs on the left-shifted remainder taken straight from acc.
  always_comb begin
    mul_sum  = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = acc[AW-1:WIDTH-1] - {2'b00, opnd};
    if (div_op) begin
      if (div_diff[WIDTH+1])
        step_next = {acc[AW-2:0], 1'b0};
      else
        step_next = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MTHI)
              hi_q <= bus.a;
            if (bus.op == OP_MTLO)
              lo_q <= bus.a;
            if (is_md && !(is_div && b_zero)) begin
              cnt    <= CNT_W'(WIDTH);
              div_op <= is_div;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              opnd   <= is_div ? b_mag : a_mag;
              acc    <= {{(WIDTH+1){1'b0}}, is_div ? a_mag : b_mag};
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            cnt <= '0;
          end else begin
            acc <= step_next;
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            if (div_op) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
            dbz_q  <= 1'b0;
          end
        end
        S_ZERO: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            dbz_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO/div_by_zero
// from an arithmetic reference model; a monitor pops and compares on every done pulse.
module tb_mul_div_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mul_div_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic [63:0] p;
    longint sa, sb, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.hi = m_hi; r.lo = m_lo; r.dbz = 1'b0;
    case (op)
      3'b000: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'b010: begin
        if (b == 0) r.dbz = 1'b1;
        else begin
          q = sa / sb; rm = sa % sb;
          p = q;  r.lo = p[31:0];
          p = rm; r.hi = p[31:0];
        end
      end
      3'b011: begin
        if (b == 0) r.dbz = 1'b1;
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", 64'(bus.hi), 64'(e.hi));
        check("result_lo", 64'(bus.lo), 64'(e.lo));
        check("result_dbz", 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Drive one start for a single cycle; returns at cycle N+1 (#1 after accept edge N).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits for done, checking latency and busy cycles; inject drives ignored starts mid-run.
  task automatic wait_done(input int exp_n, input int exp_busy, input bit inject);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1;
      else if (bus.busy) busy_n++;
      if (inject) begin
        if (n == 3)  begin bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h0000_AAAA; end
        if (n == 4)  bus.start = 1'b0;
        if (n == 8)  begin bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9; end
        if (n == 9)  bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("latency", 64'(n), 64'(exp_n));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check("busy_at_done", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    exp_t e;
    bit zero;
    zero = (op == 3'b010 || op == 3'b011) && (b == 0);
    if (op[2] == 1'b0) begin
      e = model(op, a, b);
      sb_q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
      issue(op, a, b);
      if (zero) wait_done(2, 1, inject);
      else wait_done(W + 2, W + 1, inject);
    end else begin
      if (op == 3'b100) m_hi = a;
      if (op == 3'b101) m_lo = a;
      issue(op, a, b);
      @(negedge clk);
      check("mt_busy", 64'(bus.busy), 64'(0));
      check("mt_hi", 64'(bus.hi), 64'(m_hi));
      check("mt_lo", 64'(bus.lo), 64'(m_lo));
      @(posedge clk); #1;
    end
  endtask

  task automatic abort_test(input bit use_rst);
    int dones = 0;
    issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0;
    if (use_rst) begin m_hi = '0; m_lo = '0; end
    check(use_rst ? "rst_busy" : "flush_busy", 64'(bus.busy), 64'(0));
    check(use_rst ? "rst_done" : "flush_done", 64'(bus.done), 64'(0));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check(use_rst ? "rst_no_done" : "flush_no_done", 64'(dones), 64'(0));
    check(use_rst ? "rst_hi" : "flush_hi", 64'(bus.hi), 64'(m_hi));
    check(use_rst ? "rst_lo" : "flush_lo", 64'(bus.lo), 64'(m_lo));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'(0));
    check("reset_lo", 64'(bus.lo), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clk); #1;

    run_op(3'b100, 32'h0000_1234, '0, 0);
    run_op(3'b101, 32'h0000_5678, '0, 0);
    run_op(3'b011, 32'd5, 32'd0, 0);
    check("dbz_hi_kept", 64'(bus.hi), 64'h1234);
    check("dbz_lo_kept", 64'(bus.lo), 64'h5678);
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("dbz_held", 64'(bus.div_by_zero), 64'(0));
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_min_lo", 64'(bus.lo), 64'h8000_0000);
    run_op(3'b011, 32'hDEAD_BEEF, 32'd1000, 1);
    n_tests++;
    if (bus.hi == 32'h0000_AAAA) begin
      n_fail++;
      $display("FAIL ignored_mthi: got hi=%h expected not 0000aaaa", bus.hi);
    end
    run_op(3'b110, 32'hFFFF_0000, 32'd3, 0);

    abort_test(0);
    abort_test(1);

    // flush in IDLE cancels a same-cycle start
    bus.flush = 1'b1;
    issue(3'b100, 32'h0BAD_0BAD, '0);
    bus.flush = 1'b0;
    check("idle_flush_mthi", 64'(bus.hi), 64'(m_hi));
    bus.flush = 1'b1;
    issue(3'b000, 32'd3, 32'd3);
    bus.flush = 1'b0;
    check("idle_flush_busy", 64'(bus.busy), 64'(0));

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, placed beside the execute-stage ALU and shifter.
- Handles MIPS MULT/MULTU/DIV/DIVU plus MTHI/MTLO. Operand width is parametrised.
- Runs one radix-2 step per cycle. Exposes busy/done so the hazard logic stalls MFHI/MFLO and later mul/div ops until results are valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  issue op; sampled only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  cancel in-flight op (branch/exception squash)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated by mul/div
- div_by_zero  output  1  valid with done; set if divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. Reset has priority over start and flush in the same cycle. Reset mid-operation aborts the op and clears HI/LO.
- States:
  - IDLE → RUN on start with MULT/MULTU/DIV/DIVU (divisor≠0).
  - RUN → FIX after WIDTH steps.
  - FIX → IDLE.
  - IDLE → ZERO on DIV/DIVU with b=0.
  - ZERO → IDLE.
- Accept: start is honoured only in IDLE. start while busy=1 is ignored (no queueing). Undefined op codes are no-ops.
- MTHI/MTLO: hi (or lo) ← a at the accepting edge. Visible the next cycle. No busy, no done.
- Latency:
  - Start accepted at edge N.
  - busy=1 for cycles N+1 .. N+WIDTH+1 (WIDTH RUN cycles + 1 FIX cycle).
  - HI/LO written at the edge ending FIX.
  - Cycle N+WIDTH+2: done=1, busy=0, new hi/lo visible. A new start is accepted in that same cycle.
- Signed handling:
  - Operands are converted to magnitudes at accept; result signs are recorded.
  - FIX applies two's-complement negation.
  - MULT sign = a[msb]^b[msb].
  - DIV quotient sign = a[msb]^b[msb]; remainder sign = sign of dividend. Quotient truncates toward zero.
- Multiply: shift-add over WIDTH steps; {hi,lo} = full 2*WIDTH product, exact for all inputs.
- Divide: restoring, one quotient bit per step; lo = quotient, hi = remainder.
  - DIV of MIN/−1: lo = MIN (wraps), hi = 0. No trap.
- Divide by zero: ZERO state for one cycle. Next cycle done=1, div_by_zero=1, hi/lo unchanged, busy=1 only during the ZERO cycle.
- div_by_zero is 0 on every other done pulse and is held between pulses.
- flush:
  - In RUN, FIX or ZERO: return to IDLE at that edge; hi/lo unchanged; no done pulse.
  - In IDLE: cancels a same-cycle start.
  - flush and start asserted together while busy: flush wins.
- Counter: counts WIDTH down to 0; no wrap beyond terminal. Internal accumulators are 2*WIDTH+1 bits; no intermediate overflow.

Test Plan:
- MULT a=0xFFFFFFFD (−3), b=7, start at edge N → busy cycles N+1..N+33; done at N+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done once, div_by_zero=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0, after MTHI 0x1234 / MTLO 0x5678 → done one cycle after ZERO, div_by_zero=1, hi=0x1234, lo=0x5678.
- During a DIVU run: issue start MTHI a=0xAAAA and a second MULT → both ignored; result matches the original DIVU; hi≠0xAAAA.
- MULT in progress, flush at cycle N+10 → busy=0 next cycle, no done, hi/lo preserved. Repeat with rst at N+10 → hi=lo=0, busy=0, done=0.
